// File: rtl/wb_host_master_if.sv
// Command/response streams plus Wishbone classic bus
// for the single-transfer host master.
interface wb_host_master_if #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
);
    localparam int SEL_W = DAT_W / 8;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [ADR_W-1:0] cmd_adr;
    logic [DAT_W-1:0] cmd_dat;
    logic [SEL_W-1:0] cmd_sel;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [DAT_W-1:0] rsp_dat;
    logic             rsp_err;
    logic             busy;

    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [SEL_W-1:0] wbm_sel_o;
    logic [ADR_W-1:0] wbm_adr_o;
    logic [DAT_W-1:0] wbm_dat_o;
    logic             wbm_ack_i;
    logic [DAT_W-1:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr,
        input  cmd_dat, cmd_sel, rsp_ready,
        input  wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_dat,
        output rsp_err, busy,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr,
        output cmd_dat, cmd_sel, rsp_ready,
        output wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat,
        input  rsp_err, busy,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator driven by a
// valid/ready command stream, with ack timeout.
module wb_host_master #(
    parameter int TIMEOUT = 255,
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_host_master_if.master bus
);
    localparam int SEL_W = DAT_W / 8;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam int TO_LAST = TO_EN ? TIMEOUT - 1 : 0;
    localparam logic [15:0] TO_CMP = 16'(TO_LAST);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t           state;
    logic [15:0]      cnt;
    logic             cyc_q;
    logic             we_q;
    logic [SEL_W-1:0] sel_q;
    logic [ADR_W-1:0] adr_q;
    logic [DAT_W-1:0] dat_q;
    logic             rsp_valid_q;
    logic [DAT_W-1:0] rsp_dat_q;
    logic             rsp_err_q;
    logic             busy_q;

    assign bus.cmd_ready = (state == IDLE) && !wb_rst_i;

    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        we_q   <= bus.cmd_we;
                        adr_q  <= bus.cmd_adr;
                        dat_q  <= bus.cmd_dat;
                        sel_q  <= bus.cmd_sel;
                        cyc_q  <= 1'b1;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= BUS;
                    end
                end
                BUS: begin
                    // ack takes priority over a coincident timeout
                    if (bus.wbm_ack_i) begin
                        cyc_q       <= 1'b0;
                        rsp_dat_q   <= we_q ? '0 : bus.wbm_dat_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else if (TO_EN && cnt == TO_CMP) begin
                        cyc_q       <= 1'b0;
                        rsp_dat_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_host_master.sv
// Randomized bench for wb_host_master against a
// transaction-level expectation of bus length and response.
module tb_wb_host_master;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    wb_host_master_if bus ();

    wb_host_master #(
        .TIMEOUT(TO),
        .ADR_W  (32),
        .DAT_W  (32)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [95:0] obs,
                         input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s obs=%0h exp=%0h",
                     tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_cmd();
        bus.cmd_we  = 1'($urandom);
        bus.cmd_adr = $urandom;
        bus.cmd_dat = $urandom;
        bus.cmd_sel = 4'($urandom);
    endtask

    // ack_dly: stb cycle carrying ack (0 = never)
    task automatic do_txn(input bit          we,
                          input logic [31:0] adr,
                          input logic [31:0] dat,
                          input logic [3:0]  sel,
                          input int          ack_dly,
                          input int          rsp_wait,
                          input logic [31:0] rdata);
        int          n;
        int          exp_n;
        bit          exp_err;
        logic [31:0] exp_dat;
        exp_err = !(ack_dly >= 1 && ack_dly <= TO);
        exp_n   = exp_err ? TO : ack_dly;
        exp_dat = (exp_err || we) ? 32'h0 : rdata;

        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        bus.rsp_ready = 1'b0;
        #1;
        check("cmd_ready_idle", 96'(bus.cmd_ready), 96'(1));
        tick();
        bus.cmd_valid = 1'b0;
        junk_cmd();

        n = 0;
        while (!bus.rsp_valid && n < 16) begin
            check("bus_hold",
                  {bus.wbm_cyc_o, bus.wbm_stb_o,
                   bus.wbm_we_o, bus.wbm_sel_o,
                   bus.wbm_adr_o, bus.wbm_dat_o},
                  {2'b11, we, sel, adr, dat});
            n++;
            bus.wbm_ack_i = (n == ack_dly);
            bus.wbm_dat_i = (n == ack_dly) ? rdata
                                           : $urandom;
            tick();
            bus.wbm_ack_i = 1'b0;
        end
        check("bus_cycles", 96'(n), 96'(exp_n));
        check("rsp",
              {bus.rsp_valid, bus.rsp_err, bus.rsp_dat},
              {1'b1, exp_err, exp_dat});
        check("bus_end",
              {bus.wbm_cyc_o, bus.wbm_stb_o,
               bus.busy, bus.cmd_ready},
              {4'b0010});

        for (int i = 0; i < rsp_wait; i++) begin
            bus.cmd_valid = 1'($urandom);
            bus.wbm_ack_i = 1'($urandom);
            junk_cmd();
            tick();
            check("rsp_hold",
                  {bus.rsp_valid, bus.rsp_err,
                   bus.rsp_dat, bus.wbm_cyc_o,
                   bus.cmd_ready},
                  {1'b1, exp_err, exp_dat, 2'b00});
        end

        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.wbm_ack_i = 1'b0;
        junk_cmd();
        tick();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("release",
              {bus.rsp_valid, bus.wbm_cyc_o,
               bus.busy, bus.cmd_ready},
              {4'b0001});
        check("dat_we_kept",
              {bus.wbm_we_o, bus.wbm_dat_o},
              {we, dat});
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;
        junk_cmd();
        repeat (3) tick();
        check("rst_bus",
              {bus.wbm_cyc_o, bus.wbm_stb_o,
               bus.wbm_we_o, bus.wbm_sel_o,
               bus.wbm_adr_o, bus.wbm_dat_o},
              '0);
        check("rst_rsp",
              {bus.rsp_valid, bus.rsp_err,
               bus.rsp_dat, bus.busy, bus.cmd_ready},
              '0);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 96'(bus.cmd_ready), 96'(1));

        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("stray_idle",
              {bus.rsp_valid, bus.wbm_cyc_o,
               bus.busy, bus.cmd_ready},
              {4'b0001});

        do_txn(1'b1, 32'h3000_0004, 32'h3F80_0000,
               4'hF, 3, 0, 32'hDEAD_BEEF);
        do_txn(1'b0, 32'h3000_0008, 32'h0,
               4'hF, 1, 5, 32'h4049_0FDB);
        do_txn(1'b0, 32'h3000_000C, 32'h0,
               4'hF, 0, 1, 32'h1234_5678);
        do_txn(1'b0, 32'h3000_0010, 32'h0,
               4'hF, TO, 0, 32'hCAFE_F00D);
        do_txn(1'b1, 32'h3000_0014, 32'h5555_AAAA,
               4'h3, 0, 2, 32'h0);

        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h3000_0020;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_bus",
              {bus.wbm_cyc_o, bus.wbm_stb_o,
               bus.rsp_valid, bus.busy},
              {4'b0000});
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        repeat (3) begin
            tick();
            check("late_ack",
                  {bus.rsp_valid, bus.wbm_cyc_o,
                   bus.busy},
                  {3'b000});
        end
        do_txn(1'b0, 32'h3000_0024, 32'h0,
               4'hF, 2, 0, 32'h0BAD_CAFE);

        for (int t = 0; t < 40; t++) begin
            do_txn(1'($urandom), $urandom, $urandom,
                   4'($urandom),
                   int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 3)),
                   $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, fails);
        $finish;
    end
endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic single-transfer initiator, the bus-master end for the FPU's Wishbone slave port.
- Turns a valid/ready command stream (from a pin-driven debug bridge or on-chip sequencer) into one Wishbone read or write per command.
- Returns the read data or a timeout error on a valid/ready response stream.
- Sits in the user area beside the FPU and shares the user clock domain.

Parameters:
- TIMEOUT, 255: bus cycles to wait for ack before aborting with an error. Range 1..65535; 0 disables the timeout.
- ADR_W, 32: address width.
- DAT_W, 32: data width. Fixed at 32; sel width is DAT_W/8.

Ports:
- wb_clk_i  in  1  single clock; all logic is rising-edge.
- wb_rst_i  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  ADR_W  byte address, passed through unmodified.
- cmd_dat  in  DAT_W  write data.
- cmd_sel  in  DAT_W/8  byte enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_dat  out  DAT_W  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timed out.
- busy  out  1  high in any state other than IDLE.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  DAT_W/8  Wishbone byte selects.
- wbm_adr_o  out  ADR_W  Wishbone address.
- wbm_dat_o  out  DAT_W  Wishbone write data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_dat_i  in  DAT_W  Wishbone read data.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values:
  - cyc, stb, we, sel, adr, dat_o = 0.
  - rsp_valid = 0, rsp_dat = 0, rsp_err = 0, busy = 0.
  - Timeout counter = 0; state = IDLE.
- Registering: all Wishbone outputs and rsp_* are registered. cmd_ready is combinational: (state == IDLE) && !wb_rst_i.
- IDLE:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - On that edge: latch we/adr/dat/sel onto the wbm_* outputs, set cyc = stb = 1, clear the counter, go to BUS.
- BUS:
  - cyc, stb, we, adr, dat_o, sel are held stable.
  - Each edge with ack_i = 0: counter += 1.
  - Edge with ack_i = 1:
    - cyc = stb = 0.
    - rsp_dat = we ? 0 : wbm_dat_i.
    - rsp_err = 0, rsp_valid = 1, go to RESP.
  - Edge with ack_i = 0 and TIMEOUT != 0 and counter == TIMEOUT-1:
    - cyc = stb = 0.
    - rsp_dat = 0, rsp_err = 1, rsp_valid = 1, go to RESP.
    - Result: the bus is held exactly TIMEOUT cycles.
  - If ack arrives on the same edge the timeout would fire, ack wins: normal response.
- RESP:
  - rsp_valid, rsp_dat, rsp_err held until rsp_ready is sampled high.
  - On that edge: rsp_valid = 0, go to IDLE.
  - No new command is accepted in RESP, and none on the release edge itself. The next command is accepted at the earliest on the following edge.
- Latency:
  - Command accepted at edge N → cyc/stb high from N+1.
  - ack sampled at edge M → cyc low and rsp_valid high from M+1.
  - Minimum accept-to-response is 2 edges; minimum back-to-back command spacing is 3 cycles with rsp_ready tied high.
- Stray ack: ack_i in IDLE or RESP is ignored and has no state change.
- wbm_dat_o and wbm_we_o keep their last values after the cycle ends; cyc/stb low marks them don't-care.
- Reset mid-operation:
  - Any state → IDLE on the reset edge; cyc/stb drop that edge.
  - The pending command is discarded and no response is produced.
  - A late ack after reset is ignored.
- Single outstanding transaction only; no pipelined or burst Wishbone.

Test Plan:
- Write: cmd we=1, adr=0x3000_0004, dat=0x3F80_0000, sel=0xF; slave acks 3 cycles after stb.
  - Bus shows cyc=stb=we=1 with the same adr/dat/sel for 3 cycles.
  - Then rsp_valid=1, rsp_dat=0, rsp_err=0.
- Read: cmd we=0, adr=0x3000_0008; slave acks on the first cycle with dat_i=0x4049_0FDB.
  - rsp_valid rises 2 edges after acceptance with rsp_dat=0x4049_0FDB, rsp_err=0.
- Back-pressure: rsp_ready held low 5 cycles after a read.
  - rsp_valid, rsp_dat, rsp_err stable throughout; cmd_ready=0 throughout; a cmd_valid pulse is not accepted.
  - After rsp_ready=1, cmd_ready=1 one cycle later.
- Timeout: TIMEOUT=4, no ack.
  - cyc/stb high exactly 4 cycles, then rsp_err=1, rsp_dat=0.
  - Variant with ack on the 4th cycle: rsp_err=0.
- Reset mid-BUS: reset asserted on the 2nd stb cycle.
  - cyc/stb=0 next cycle, rsp_valid never asserts.
  - An ack 1 cycle later is ignored; the next command completes normally.
- Stray ack: ack_i pulsed in IDLE and RESP → no state change, no extra rsp_valid.
